// File: rtl/shift_reg_pkg.sv
// Shared encodings for the universal shift register: operation codes,
// burst FSM states and burst direction constants.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_CLEAR = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_reg_next_value.sv
// Combinational next-value datapath shared by the Mode_In path and the burst path.
// Optional macro: ARITH_SHIFT_EN (right shifts sign-extend instead of using the serial fill).
module shift_reg_next_value
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] load_i,
  input  logic             fill_left_i,
  input  logic             fill_right_i,
  output logic [WIDTH-1:0] q_next_o
);

  logic right_fill_s;

  // Select the bit that enters the MSB on a right shift
  always_comb begin
`ifdef ARITH_SHIFT_EN
    right_fill_s = q_i[WIDTH-1];
`else
    right_fill_s = fill_right_i;
`endif
  end

  // Operation decode; reserved code and hold keep the current value
  always_comb begin
    q_next_o = q_i;
    case (op_i)
      MODE_HOLD:  q_next_o = q_i;
      MODE_SHL:   q_next_o = {q_i[WIDTH-2:0], fill_left_i};
      MODE_SHR:   q_next_o = {right_fill_s, q_i[WIDTH-1:1]};
      MODE_ROL:   q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ROR:   q_next_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_LOAD:  q_next_o = load_i;
      MODE_CLEAR: q_next_o = {WIDTH{1'b0}};
      MODE_RSVD:  q_next_o = q_i;
      default:    q_next_o = q_i;
    endcase
  end

`ifdef ARITH_SHIFT_EN
  logic unused_fill_s;
  assign unused_fill_s = fill_right_i;
`endif

endmodule

// File: rtl/universal_shift_register_n_bit.sv
// WIDTH-bit universal shift register with an autonomous N-position burst mode
// (start/busy/done handshake). Falling-edge clocked. Optional macro: ARITH_SHIFT_EN.
module universal_shift_register_n_bit
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             Enable_In,
  input  logic [2:0]       Mode_In,
  input  logic [WIDTH-1:0] Parallel_Data_In,
  input  logic             Serial_Left_In,
  input  logic             Serial_Right_In,
  input  logic             Burst_Start_In,
  input  logic [CNT_W-1:0] Burst_Count_In,
  input  logic             Burst_Dir_In,
  output logic [WIDTH-1:0] Parallel_Data_Out,
  output logic             Serial_Left_Out,
  output logic             Serial_Right_Out,
  output logic             Busy_Out,
  output logic             Done_Out
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       op_s;
  logic [CNT_W-1:0] cnt_sat_s;
  logic [WIDTH-1:0] data_next_s;

  // Requests longer than the register width are clamped to WIDTH shifts
  always_comb begin
    if (Burst_Count_In > CNT_W'(WIDTH)) begin
      cnt_sat_s = CNT_W'(WIDTH);
    end else begin
      cnt_sat_s = Burst_Count_In;
    end
  end

  // Datapath operation: burst direction while running, Mode_In only when idle and enabled
  always_comb begin
    op_s = MODE_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (Burst_Start_In) begin
          op_s = MODE_HOLD;
        end else if (Enable_In) begin
          op_s = Mode_In;
        end else begin
          op_s = MODE_HOLD;
        end
      end
      ST_BURST: begin
        if (dir_q == DIR_RIGHT) begin
          op_s = MODE_SHR;
        end else begin
          op_s = MODE_SHL;
        end
      end
      default: op_s = MODE_HOLD;
    endcase
  end

  shift_reg_next_value #(
    .WIDTH (WIDTH)
  ) u_next_value (
    .q_i          (data_q),
    .op_i         (op_s),
    .load_i       (Parallel_Data_In),
    .fill_left_i  (Serial_Left_In),
    .fill_right_i (Serial_Right_In),
    .q_next_o     (data_next_s)
  );

  // Burst FSM, counter and handshake flags
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    data_d  = data_next_s;
    case (state_q)
      ST_IDLE: begin
        if (Burst_Start_In) begin
          if (Burst_Count_In != {CNT_W{1'b0}}) begin
            state_d = ST_BURST;
            cnt_d   = cnt_sat_s;
            dir_d   = Burst_Dir_In;
            busy_d  = 1'b1;
          end else begin
            // Zero-length burst completes immediately with only a done pulse
            done_d  = 1'b1;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_BURST: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = {CNT_W{1'b0}};
        busy_d  = 1'b0;
        data_d  = data_q;
      end
    endcase
  end

  // State and data registers, updated on the falling clock edge
  always_ff @(negedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      dir_q   <= DIR_LEFT;
      data_q  <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Parallel_Data_Out = data_q;
  assign Serial_Left_Out   = data_q[WIDTH-1];
  assign Serial_Right_Out  = data_q[0];
  assign Busy_Out          = busy_q;
  assign Done_Out          = done_q;

endmodule
